// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-atomic round-robin arbiter in front of the UART TX FIFO
// Optional grant-id header byte before each packet: define UART_ARB_ID_HDR_EN.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int MAX_PKT = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [8*NREQ-1:0]        req_data,
  input  logic [NREQ-1:0]          req_last,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     fifo_full,
  output logic                     fifo_wr_en,
  output logic [7:0]               fifo_wr_data,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy,
  output logic                     trunc_err
);

  localparam int IDW = $clog2(NREQ);

`ifdef UART_ARB_ID_HDR_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HDR = 2'd1, S_XFER = 2'd2} state_e;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_XFER = 2'd2} state_e;
`endif

  state_e         state_q, state_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           trunc_q, trunc_d;
  logic           busy_q;

  logic           win_found;
  logic [IDW-1:0] win_idx;

  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] g);
    if (int'(g) == NREQ - 1) return '0;
    return g + 1'b1;
  endfunction

  // Scan from the highest offset down so the nearest valid requester above ptr wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[rr_idx(ptr_q, i)]) begin
        win_found = 1'b1;
        win_idx   = rr_idx(ptr_q, i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    trunc_d      = 1'b0;
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = 8'h00;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_d = win_idx;
          cnt_d   = '0;
`ifdef UART_ARB_ID_HDR_EN
          state_d = S_HDR;
`else
          state_d = S_XFER;
`endif
        end
      end
`ifdef UART_ARB_ID_HDR_EN
      S_HDR: begin
        if (!fifo_full) begin
          fifo_wr_en   = 1'b1;
          fifo_wr_data = 8'hA0 | 8'(grant_q);
          state_d      = S_XFER;
        end
      end
`endif
      S_XFER: begin
        req_ready[grant_q] = !fifo_full;
        fifo_wr_data       = req_data[8*grant_q +: 8];
        fifo_wr_en         = req_valid[grant_q] & !fifo_full;
        if (fifo_wr_en) begin
          cnt_d = cnt_q + 8'd1;
          // A last byte landing exactly on the limit is a clean end, not a truncation.
          if (req_last[grant_q]) begin
            state_d = S_IDLE;
            ptr_d   = next_ptr(grant_q);
          end else if (cnt_d == 8'(MAX_PKT)) begin
            state_d = S_IDLE;
            ptr_d   = next_ptr(grant_q);
            trunc_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      trunc_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      trunc_q <= trunc_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign grant_id  = grant_q;
  assign busy      = busy_q;
  assign trunc_err = trunc_q;

endmodule
